// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, drives the instruction
//               memory port, buffers fetched words in a small circular FIFO
//               and hands them to decode over a valid/ready handshake.
//               Handles decode stalls, taken-branch redirects and HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DEPTH       = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [4:0]            HALT_OPCODE = 5'b00000
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction memory port
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_en,
  output logic                  imem_wr,
  output logic [15:0]           imem_din,
  input  logic [15:0]           imem_dout,
  // redirect from execute
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  // decode handshake
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [15:0]           id_instr,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc_plus2,
  output logic                  halted
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(2);
  // Instructions are halfword aligned: bit 0 of any address is forced low.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(1));

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  pc;

  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;

  logic [15:0]            fifo_instr    [DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc       [DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc_plus2 [DEPTH];

  logic                   redirect_act;
  logic                   pop_req;
  logic                   space;
  logic                   fetch;
  logic                   pop;
  logic                   is_halt;
  logic [ADDR_WIDTH-1:0]  pc_seq;

  // A redirect is meaningless before the first fetch cycle, so IDLE ignores it.
  assign redirect_act = redirect & (state != S_IDLE);

  assign id_valid = (count != '0);
  assign pop_req  = id_valid & id_ready;

  // A slot frees up this cycle if decode takes the head, so a full FIFO can
  // still accept a new word in the same cycle.
  assign space = (count < FULL_COUNT) | pop_req;

  // Redirect suppresses both ends of the FIFO: the contents are wrong-path.
  assign fetch   = (state == S_FETCH) & space & ~redirect_act;
  assign pop     = pop_req & ~redirect_act;

  assign pc_seq  = pc + PC_STEP;
  assign is_halt = (imem_dout[15:11] == HALT_OPCODE);

  assign imem_en   = fetch;
  assign imem_addr = pc;
  assign imem_wr   = 1'b0;
  assign imem_din  = 16'h0000;

  // Head outputs are forced to zero while the FIFO is empty so decode never
  // sees stale data from a previously popped or flushed slot.
  assign id_instr    = id_valid ? fifo_instr[rd_ptr]    : 16'h0000;
  assign id_pc       = id_valid ? fifo_pc[rd_ptr]       : '0;
  assign id_pc_plus2 = id_valid ? fifo_pc_plus2[rd_ptr] : '0;

  // Control FSM: owns state, PC and the registered halted flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (redirect_act) begin
      // A pending HALT may itself be wrong-path, so redirect leaves HALTED too.
      state  <= S_FETCH;
      pc     <= redirect_pc & ALIGN_MASK;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // One dead cycle after reset gives the memory time to load.
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (fetch) begin
            pc <= pc_seq;
            if (is_halt) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          // Fetch stopped; the FIFO keeps draining to decode.
          state <= S_HALTED;
        end
        default: begin
          state  <= S_IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_act) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({fetch, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: captures the combinational memory word alongside its address.
  always_ff @(posedge clk) begin
    if (fetch) begin
      fifo_instr[wr_ptr]    <= imem_dout;
      fifo_pc[wr_ptr]       <= pc;
      fifo_pc_plus2[wr_ptr] <= pc_seq;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed scenarios plus a
//               randomized run checked against a program-order stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic        imem_wr;
  logic [15:0] imem_din;
  logic [15:0] imem_dout;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus2;
  logic        halted;

  logic [15:0] mem [0:32767];

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .ADDR_WIDTH (16),
    .DEPTH      (DEPTH),
    .RESET_PC   (16'h0000),
    .HALT_OPCODE(5'b00000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_wr    (imem_wr),
    .imem_din   (imem_din),
    .imem_dout  (imem_dout),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus2(id_pc_plus2),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Combinational read memory, word indexed by the halfword address.
  assign imem_dout = mem[imem_addr[15:1]];

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:11] == 5'b00000) w[15] = 1'b1;  // keep HALT out of random code
    return w;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 32768; i++) mem[i] = rand_word();
  endtask

  // Drive one cycle's inputs at the falling edge and let outputs settle.
  task automatic step(input logic rdy, input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    id_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  // Hold reset over two edges, release at a falling edge; returns in IDLE cycle.
  task automatic do_reset();
    rst = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_en, id_valid, halted, imem_wr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl en/valid/halted/wr=%b expected 0000", {imem_en, id_valid, halted, imem_wr});
    end
    checks++;
    if ({id_instr, id_pc, id_pc_plus2, imem_din} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data instr=%h pc=%h pc2=%h din=%h expected all 0", id_instr, id_pc, id_pc_plus2, imem_din);
    end
    do_reset();
    checks++;
    if (imem_en !== 1'b0) begin
      errors++; $display("FAIL idle_no_fetch imem_en=%b expected 0", imem_en);
    end
  endtask

  task automatic test_basic();
    logic [15:0] w [4];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;
    for (int i = 0; i < 4; i++) mem[i] = w[i];
    do_reset();
    step(1'b1, 1'b0, 16'h0);
    checks++;
    if ({imem_en, imem_addr, id_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL basic_first_fetch en=%b addr=%h valid=%b expected 1 0000 0", imem_en, imem_addr, id_valid);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 16'h0);
      checks++;
      if ({id_valid, id_instr, id_pc, id_pc_plus2} !== {1'b1, w[k], 16'(2*k), 16'(2*k+2)}) begin
        errors++;
        $display("FAIL basic_deliver%0d valid=%b instr=%h pc=%h pc2=%h expected 1 %h %h %h",
                 k, id_valid, id_instr, id_pc, id_pc_plus2, w[k], 16'(2*k), 16'(2*k+2));
      end
    end
  endtask

  task automatic test_stall();
    int fetches;
    logic [15:0] w [4];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;
    for (int i = 0; i < 4; i++) mem[i] = w[i];
    do_reset();
    fetches = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 16'h0);
      if (imem_en === 1'b1) fetches++;
      if (c > 0) begin
        checks++;
        if ({id_valid, id_instr} !== {1'b1, 16'h1111}) begin
          errors++; $display("FAIL stall_head_c%0d valid=%b instr=%h expected 1 1111", c, id_valid, id_instr);
        end
      end
    end
    checks++;
    if (fetches != DEPTH) begin
      errors++; $display("FAIL stall_push_count got=%0d expected %0d", fetches, DEPTH);
    end
    checks++;
    if ({imem_en, imem_addr} !== {1'b0, 16'h0004}) begin
      errors++; $display("FAIL stall_pc_hold en=%b addr=%h expected 0 0004", imem_en, imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 16'h0);
      checks++;
      if ({id_valid, id_instr, id_pc} !== {1'b1, w[k], 16'(2*k)}) begin
        errors++;
        $display("FAIL stall_release%0d valid=%b instr=%h pc=%h expected 1 %h %h", k, id_valid, id_instr, id_pc, w[k], 16'(2*k));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0041);
    checks++;
    if (imem_en !== 1'b0) begin
      errors++; $display("FAIL redir_cycle_en imem_en=%b expected 0", imem_en);
    end
    step(1'b0, 1'b0, 16'h0);
    checks++;
    if ({id_valid, imem_en, imem_addr} !== {1'b0, 1'b1, 16'h0040}) begin
      errors++; $display("FAIL redir_flush valid=%b en=%b addr=%h expected 0 1 0040", id_valid, imem_en, imem_addr);
    end
    step(1'b0, 1'b0, 16'h0);
    checks++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 16'h0040, mem[16'h0020]}) begin
      errors++;
      $display("FAIL redir_target valid=%b pc=%h instr=%h expected 1 0040 %h", id_valid, id_pc, id_instr, mem[16'h0020]);
    end
  endtask

  task automatic test_halt();
    logic [15:0] saved;
    saved  = mem[3];
    mem[3] = 16'h0000;
    do_reset();
    repeat (4) step(1'b1, 1'b0, 16'h0);
    checks++;
    if ({halted, id_pc} !== {1'b0, 16'h0004}) begin
      errors++; $display("FAIL halt_pre halted=%b pc=%h expected 0 0004", halted, id_pc);
    end
    step(1'b1, 1'b0, 16'h0);
    checks++;
    if ({id_valid, id_pc, id_instr, halted, imem_en} !== {1'b1, 16'h0006, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL halt_deliver valid=%b pc=%h instr=%h halted=%b en=%b expected 1 0006 0000 1 0",
               id_valid, id_pc, id_instr, halted, imem_en);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 16'h0);
      checks++;
      if ({imem_en, halted, id_valid} !== 3'b010) begin
        errors++; $display("FAIL halt_hold%0d en/halted/valid=%b expected 010", c, {imem_en, halted, id_valid});
      end
    end
    step(1'b1, 1'b1, 16'h0010);
    step(1'b1, 1'b0, 16'h0);
    checks++;
    if ({imem_en, imem_addr, halted} !== {1'b1, 16'h0010, 1'b0}) begin
      errors++; $display("FAIL halt_resume en=%b addr=%h halted=%b expected 1 0010 0", imem_en, imem_addr, halted);
    end
    mem[3] = saved;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (4) step(1'b1, 1'b0, 16'h0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_en, id_valid, halted, id_instr, id_pc} !== 35'h0) begin
      errors++;
      $display("FAIL async_reset en=%b valid=%b halted=%b instr=%h pc=%h expected all 0",
               imem_en, id_valid, halted, id_instr, id_pc);
    end
    do_reset();
    checks++;
    if (imem_en !== 1'b0) begin
      errors++; $display("FAIL async_idle imem_en=%b expected 0", imem_en);
    end
    step(1'b1, 1'b0, 16'h0);
    checks++;
    if ({imem_en, imem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL async_restart en=%b addr=%h expected 1 0000", imem_en, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'hFFFE);
    step(1'b1, 1'b0, 16'h0);
    checks++;
    if ({imem_en, imem_addr} !== {1'b1, 16'hFFFE}) begin
      errors++; $display("FAIL wrap_fetch en=%b addr=%h expected 1 fffe", imem_en, imem_addr);
    end
    step(1'b1, 1'b0, 16'h0);
    checks++;
    if ({id_pc, id_pc_plus2, imem_addr} !== {16'hFFFE, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_pc pc=%h pc2=%h addr=%h expected fffe 0000 0000", id_pc, id_pc_plus2, imem_addr);
    end
  endtask

  // Random stall/redirect traffic against a program-order model: fetch and
  // delivery each follow PC+2 from the last redirect target, and occupancy is
  // the difference between words fetched and words accepted.
  task automatic test_random();
    logic [15:0] exp_fetch, exp_deliver, prev_instr, prev_pc, rpc;
    logic        rdy, rd, acc, fet, prev_hold;
    int          occ;
    fill_mem();
    do_reset();
    exp_fetch = 16'h0000; exp_deliver = 16'h0000; occ = 0; prev_hold = 1'b0;
    prev_instr = 16'h0; prev_pc = 16'h0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 39) == 0);
      rpc = 16'($urandom);
      step(rdy, rd, rpc);
      checks++;
      if ({id_valid, halted} !== {(occ != 0), 1'b0}) begin
        errors++; $display("FAIL rand_valid c=%0d valid=%b halted=%b expected %b 0", c, id_valid, halted, (occ != 0));
      end
      if (prev_hold) begin
        checks++;
        if ({id_instr, id_pc} !== {prev_instr, prev_pc}) begin
          errors++; $display("FAIL rand_stable c=%0d instr=%h pc=%h expected %h %h", c, id_instr, id_pc, prev_instr, prev_pc);
        end
      end
      if (rd) begin
        checks++;
        if (imem_en !== 1'b0) begin
          errors++; $display("FAIL rand_redir_en c=%0d en=%b expected 0", c, imem_en);
        end
        exp_fetch   = rpc & 16'hFFFE;
        exp_deliver = rpc & 16'hFFFE;
        occ         = 0;
        prev_hold   = 1'b0;
      end else begin
        acc = id_valid & rdy;
        fet = imem_en;
        checks++;
        if (imem_en !== ((occ < DEPTH) || acc)) begin
          errors++; $display("FAIL rand_space c=%0d en=%b expected %b", c, imem_en, ((occ < DEPTH) || acc));
        end
        if (acc) begin
          checks++;
          if ({id_pc, id_instr, id_pc_plus2} !== {exp_deliver, mem[exp_deliver[15:1]], 16'(exp_deliver + 16'd2)}) begin
            errors++;
            $display("FAIL rand_deliver c=%0d pc=%h instr=%h pc2=%h expected %h %h %h", c, id_pc, id_instr,
                     id_pc_plus2, exp_deliver, mem[exp_deliver[15:1]], 16'(exp_deliver + 16'd2));
          end
          exp_deliver = exp_deliver + 16'd2;
        end
        if (fet) begin
          checks++;
          if (imem_addr !== exp_fetch) begin
            errors++; $display("FAIL rand_fetch_addr c=%0d addr=%h expected %h", c, imem_addr, exp_fetch);
          end
          exp_fetch = exp_fetch + 16'd2;
        end
        occ        = occ + (fet ? 1 : 0) - (acc ? 1 : 0);
        prev_hold  = id_valid & ~rdy;
        prev_instr = id_instr;
        prev_pc    = id_pc;
      end
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
